// File: rtl/max_unpool_upsampler_if.sv
// Stream bundle for the 2x unpooling block: pooled pixels in, upsampled pixels out.
// slave  : block side (consumes in_*, produces out_* and frame_done).
// master : source/sink side (produces in_*, out_ready; observes the rest).
interface max_unpool_upsampler_if #(
  parameter int data_width = 8
);
  logic [data_width-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  frame_done;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, frame_done
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, frame_done
  );
endinterface

// File: rtl/max_unpool_upsampler.sv
// 2x nearest-neighbour unpooling: each pooled pixel becomes a 2x2 block, raster order.
// Ports: clk, rst (async active-high), bus = slave side of max_unpool_upsampler_if.
// Latency one cycle input->first copy; out_valid/out_data hold while out_ready is low.
module max_unpool_upsampler #(
  parameter int data_width = 8,
  parameter int in_width   = 14,
  parameter int in_height  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  max_unpool_upsampler_if.slave bus
);

  localparam int cw = (in_width  > 1) ? $clog2(in_width)  : 1;
  localparam int rw = (in_height > 1) ? $clog2(in_height) : 1;
  localparam logic [cw-1:0] col_last = cw'(in_width - 1);
  localparam logic [rw-1:0] row_last = rw'(in_height - 1);

  localparam logic [0:0] st_fill   = 1'b0;
  localparam logic [0:0] st_replay = 1'b1;

  logic [0:0]            state;
  logic [cw-1:0]         col;
  logic [rw-1:0]         row;
  logic                  dup;
  logic [data_width-1:0] out_data_q;
  logic                  out_valid_q;
  logic                  frame_done_q;

  // Sized to a power of two so the column counter indexes it without a width mismatch.
  logic [data_width-1:0] row_buf [2**cw];

  logic                  in_fire;
  logic                  out_fire;
  logic [cw-1:0]         col_next;
  logic [cw-1:0]         wr_col;
  logic                  in_ready_c;

  assign col_next = col + 1'b1;

  // While a pixel is still being shown, an accepted input belongs to the next column.
  assign wr_col = out_valid_q ? col_next : col;

  // The last column of a FILL row must not take a new pixel: REPLAY follows.
  assign in_ready_c = !rst && (state == st_fill) &&
                      (!out_valid_q || (bus.out_ready && dup && (col != col_last)));

  assign in_fire  = bus.in_valid && in_ready_c;
  assign out_fire = out_valid_q && bus.out_ready;

  assign bus.in_ready   = in_ready_c;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;

  // Row buffer is never cleared; every entry is written in FILL before REPLAY reads it.
  always_ff @(posedge clk) begin
    if (in_fire) row_buf[wr_col] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= st_fill;
      col          <= '0;
      row          <= '0;
      dup          <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state)
        st_fill: begin
          if (out_fire) begin
            if (!dup) begin
              dup <= 1'b1;
            end else begin
              dup <= 1'b0;
              if (!in_fire) out_valid_q <= 1'b0;
              if (col == col_last) begin
                state <= st_replay;
                col   <= '0;
              end else begin
                col <= col_next;
              end
            end
          end
          // A new pixel overrides the drop of out_valid above: no bubble at full rate.
          if (in_fire) begin
            out_data_q  <= bus.in_data;
            out_valid_q <= 1'b1;
            dup         <= 1'b0;
          end
        end
        default: begin
          if (!out_valid_q) begin
            // First cycle of REPLAY: present column 0 from the buffer.
            out_data_q  <= row_buf[col];
            out_valid_q <= 1'b1;
          end else if (out_fire) begin
            if (!dup) begin
              dup <= 1'b1;
            end else begin
              dup <= 1'b0;
              if (col == col_last) begin
                out_valid_q <= 1'b0;
                col         <= '0;
                state       <= st_fill;
                if (row == row_last) begin
                  row          <= '0;
                  frame_done_q <= 1'b1;
                end else begin
                  row <= row + 1'b1;
                end
              end else begin
                col        <= col_next;
                out_data_q <= row_buf[col_next];
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/max_unpool_upsampler.md
Name: max_unpool_upsampler

Overview:
- Streaming 2x nearest-neighbour unpooling (upsampling) block: the inverse direction of the 2x2 pooling stage.
- Accepts a pooled feature map, raster order, one pixel per handshake. Emits a feature map twice as wide and twice as tall: each input pixel becomes a 2x2 block of identical pixels.
- Sits between a pooled-map source (buffer or layer output) and a downstream consumer expecting full-resolution maps.
- One input row is held in an internal row buffer so it can be replayed for the second output row.

Parameters:
- data_width, 8, pixel width in bits; passed through unmodified.
- in_width, 14, pooled row length in pixels (>=1); output row length is 2*in_width.
- in_height, 14, pooled rows per frame (>=1); output rows per frame is 2*in_height.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  data_width  pooled pixel.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  data_width  upsampled pixel, registered.
- out_valid  output  1  out_data valid, registered.
- out_ready  input  1  downstream accepts out_data this cycle.
- frame_done  output  1  one-cycle pulse, registered, after the last output pixel of a frame is consumed.

Behaviour:
- Reset (async, active-high):
  - out_valid=0, out_data=0, frame_done=0.
  - State=FILL, col=0, row=0, dup=0.
  - in_ready=0 while rst is high.
  - Row buffer contents are not cleared; they are always overwritten in FILL before being read.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid=1 && out_ready=0, out_data and out_valid hold stable.
  - in_valid may drop at any time without effect.
- Counters:
  - col counts 0..in_width-1.
  - row counts 0..in_height-1.
  - dup counts 0..1 and selects the first or second copy of the current pixel.
- State FILL (first output row of each pair):
  - in_ready = !out_valid || (out_ready && dup==1).
  - On input transfer: buf[col] <= in_data, out_data <= in_data, out_valid <= 1, dup <= 0.
  - On output transfer with dup==0: dup <= 1; same data is re-presented.
  - On output transfer with dup==1:
    - If no simultaneous input transfer: out_valid <= 0.
    - If col==in_width-1: go to REPLAY, col <= 0, no further input is accepted.
    - Otherwise: col <= col+1.
  - Simultaneous last-copy consume and new input in the same cycle is legal. It gives one output per cycle at full throughput, with no bubble.
- State REPLAY (second output row of each pair):
  - in_ready=0.
  - out_data <= buf[col], out_valid=1; the first replay pixel is presented on the cycle after entering REPLAY.
  - dup toggles on each output transfer; col advances after the dup==1 transfer.
  - After the dup==1 transfer at col==in_width-1:
    - out_valid <= 0, col <= 0, return to FILL.
    - If row==in_height-1: row <= 0 and frame_done=1 for exactly one cycle.
    - Otherwise: row <= row+1.
- Latency:
  - First copy of an input pixel appears on out_data the cycle after its input transfer.
  - FILL to REPLAY introduces at most one bubble cycle (out_valid=0).
- Totals:
  - Each frame yields exactly 4*in_width*in_height output transfers for in_width*in_height input transfers.
  - Output order is row-major at 2*in_width per row.
- Degenerate in_width=1: FILL accepts one pixel, emits 2 copies, REPLAY emits 2 copies, then back to FILL.
- Reset mid-frame: all in-flight data discarded, counters and state return to reset values, and the next input transfer is treated as pixel (0,0) of a new frame.
- No arithmetic on pixel data: the sign bit and all bits pass through bit-exact.

Test Plan:
- in_width=4, in_height=2, out_ready=1, inputs 1,2,3,4,5,6,7,8 back-to-back:
  - Outputs are 1,1,2,2,3,3,4,4, 1,1,2,2,3,3,4,4, 5,5,6,6,7,7,8,8, 5,5,6,6,7,7,8,8 (32 transfers).
  - frame_done pulses once, the cycle after the final 8 is consumed.
- Same stimulus with out_ready toggling 1,0,1,0:
  - Identical output sequence.
  - out_data is stable on every stalled cycle.
  - in_ready is 0 whenever a second copy is pending and not consumed.
- in_valid low during REPLAY: in_ready stays 0 throughout REPLAY, and no input is lost or duplicated when in_valid reasserts with value 9 in the next FILL.
- Sign/width check, data_width=8: input 8'h80 then 8'hFF appear unmodified as 80,80,FF,FF, repeated in the replay row.
- Assert rst during REPLAY of row 0:
  - out_valid drops immediately and frame_done stays 0.
  - After release, inputs 11..18 produce the full 32-pixel frame from 11, with no stale row-0 data.
- in_width=1, in_height=1, input 42: outputs 42,42,42,42, then frame_done, then in_ready=1 for the next frame.
